// File: rtl/memory_stage_pkg.sv
// Shared encodings and helpers for the pipeline MEM stage.
package memory_stage_pkg;

  // Access size codes carried on PIP_mem_size_i
  localparam logic [1:0] MEM_SIZE_B   = 2'b00;
  localparam logic [1:0] MEM_SIZE_H   = 2'b01;
  localparam logic [1:0] MEM_SIZE_W   = 2'b10;
  localparam logic [1:0] MEM_SIZE_ILL = 2'b11;

  // Data-memory transaction FSM
  typedef enum logic [0:0] {
    MEM_FSM_IDLE = 1'b0,
    MEM_FSM_WAIT = 1'b1
  } mem_fsm_e;

  // What the MEM/WB register captures on the next edge
  typedef enum logic [1:0] {
    WB_BUBBLE = 2'b00,
    WB_PASS   = 2'b01,
    WB_TRAP   = 2'b10,
    WB_LOAD   = 2'b11
  } wb_sel_e;

  // Misaligned, illegal-size or read+write access; only meaningful for memory ops
  function automatic logic access_fault(input logic       rd,
                                        input logic       wr,
                                        input logic [1:0] size,
                                        input logic [1:0] off);
    logic f;
    f = (rd & wr)
      | (size == MEM_SIZE_ILL)
      | ((size == MEM_SIZE_H) & off[0])
      | ((size == MEM_SIZE_W) & (off != 2'b00));
    return (rd | wr) & f;
  endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// Selects the addressed lane of a load word and extends it to 32 bits.
module mem_load_align
  import memory_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted_s;

  // Lane shift followed by zero/sign extension according to access size
  always_comb begin
    shifted_s = rdata >> {offset, 3'b000};
    data      = rdata;
    case (size)
      MEM_SIZE_B: begin
        if (is_unsigned) begin
          data = {24'h00_0000, shifted_s[7:0]};
        end else begin
          data = {{24{shifted_s[7]}}, shifted_s[7:0]};
        end
      end
      MEM_SIZE_H: begin
        if (is_unsigned) begin
          data = {16'h0000, shifted_s[15:0]};
        end else begin
          data = {{16{shifted_s[15]}}, shifted_s[15:0]};
        end
      end
      MEM_SIZE_W: data = rdata;
      default:    data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: drives the data-memory port, stalls on outstanding
// loads, flags faulting accesses and produces the MEM/WB registers.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  PIP_write_mem_i,
  input  logic                  PIP_read_mem_i,
  input  logic [31:0]           PIP_alu_result_i,
  input  logic [31:0]           PIP_second_operand_i,
  input  logic [1:0]            PIP_mem_size_i,
  input  logic                  PIP_mem_unsigned_i,
  input  logic                  PIP_use_mem_i,
  input  logic                  PIP_write_reg_i,
  input  logic [4:0]            PIP_rd_i,
  input  logic                  PIP_TRAP_i,
  output logic                  dmem_req_valid_o,
  input  logic                  dmem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic                  dmem_we_o,
  output logic [3:0]            dmem_be_o,
  output logic [31:0]           dmem_wdata_o,
  input  logic                  dmem_rsp_valid_i,
  input  logic [31:0]           dmem_rdata_i,
  output logic                  stall_o,
  output logic                  PIP_use_mem_o,
  output logic                  PIP_write_reg_o,
  output logic [4:0]            PIP_rd_o,
  output logic [31:0]           PIP_alu_result_o,
  output logic [31:0]           PIP_mem_data_o,
  output logic                  PIP_TRAP_o
);

  mem_fsm_e    state_r, state_next_s;
  wb_sel_e     wb_sel_s;
  logic        fault_s, trap_s, is_load_s, is_store_s;
  logic        req_valid_s, stall_s;
  logic [1:0]  off_r, size_r;
  logic        unsigned_r;
  logic [3:0]  be_s;
  logic [31:0] wdata_s, load_data_s;

  assign fault_s    = access_fault(PIP_read_mem_i, PIP_write_mem_i,
                                   PIP_mem_size_i, PIP_alu_result_i[1:0]);
  assign trap_s     = PIP_TRAP_i | fault_s;
  assign is_load_s  = PIP_read_mem_i  & ~trap_s;
  assign is_store_s = PIP_write_mem_i & ~trap_s;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= MEM_FSM_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: a load leaves IDLE once accepted, returns on its response
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      MEM_FSM_IDLE: begin
        if (is_load_s && dmem_req_ready_i) begin
          state_next_s = MEM_FSM_WAIT;
        end else begin
          state_next_s = MEM_FSM_IDLE;
        end
      end
      MEM_FSM_WAIT: begin
        if (dmem_rsp_valid_i) begin
          state_next_s = MEM_FSM_IDLE;
        end else begin
          state_next_s = MEM_FSM_WAIT;
        end
      end
      default: state_next_s = MEM_FSM_IDLE;
    endcase
  end

  // FSM outputs: request/stall handshake and what MEM/WB captures this cycle
  always_comb begin
    req_valid_s = 1'b0;
    stall_s     = 1'b0;
    wb_sel_s    = WB_BUBBLE;
    case (state_r)
      MEM_FSM_IDLE: begin
        if (trap_s) begin
          wb_sel_s = WB_TRAP;
        end else if (is_store_s) begin
          req_valid_s = 1'b1;
          stall_s     = ~dmem_req_ready_i;
          wb_sel_s    = dmem_req_ready_i ? WB_PASS : WB_BUBBLE;
        end else if (is_load_s) begin
          req_valid_s = 1'b1;
          stall_s     = 1'b1;
          wb_sel_s    = WB_BUBBLE;
        end else begin
          wb_sel_s = WB_PASS;
        end
      end
      MEM_FSM_WAIT: begin
        if (dmem_rsp_valid_i) begin
          wb_sel_s = WB_LOAD;
        end else begin
          stall_s  = 1'b1;
          wb_sel_s = WB_BUBBLE;
        end
      end
      default: begin
        req_valid_s = 1'b0;
        stall_s     = 1'b0;
        wb_sel_s    = WB_BUBBLE;
      end
    endcase
  end

  // Store lane formatting: byte enables shifted to the lane, data replicated
  always_comb begin
    be_s    = 4'b1111;
    wdata_s = PIP_second_operand_i;
    if (PIP_write_mem_i) begin
      case (PIP_mem_size_i)
        MEM_SIZE_B: begin
          be_s    = 4'b0001 << PIP_alu_result_i[1:0];
          wdata_s = {4{PIP_second_operand_i[7:0]}};
        end
        MEM_SIZE_H: begin
          be_s    = 4'b0011 << PIP_alu_result_i[1:0];
          wdata_s = {2{PIP_second_operand_i[15:0]}};
        end
        default: begin
          be_s    = 4'b1111;
          wdata_s = PIP_second_operand_i;
        end
      endcase
    end else begin
      be_s    = 4'b1111;
      wdata_s = PIP_second_operand_i;
    end
  end

  assign dmem_req_valid_o = req_valid_s;
  assign dmem_addr_o      = {PIP_alu_result_i[ADDR_WIDTH-1:2], 2'b00};
  assign dmem_we_o        = req_valid_s & PIP_write_mem_i;
  assign dmem_be_o        = be_s;
  assign dmem_wdata_o     = wdata_s;
  assign stall_o          = stall_s;

  // Capture lane offset and extension mode when the load is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      off_r      <= 2'b00;
      size_r     <= 2'b00;
      unsigned_r <= 1'b0;
    end else if ((state_r == MEM_FSM_IDLE) && is_load_s && dmem_req_ready_i) begin
      off_r      <= PIP_alu_result_i[1:0];
      size_r     <= PIP_mem_size_i;
      unsigned_r <= PIP_mem_unsigned_i;
    end else begin
      off_r      <= off_r;
      size_r     <= size_r;
      unsigned_r <= unsigned_r;
    end
  end

  mem_load_align u_load_align (
    .rdata       (dmem_rdata_i),
    .offset      (off_r),
    .size        (size_r),
    .is_unsigned (unsigned_r),
    .data        (load_data_s)
  );

  // MEM/WB pipeline register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      PIP_use_mem_o    <= 1'b0;
      PIP_write_reg_o  <= 1'b0;
      PIP_rd_o         <= 5'd0;
      PIP_alu_result_o <= 32'h0000_0000;
      PIP_mem_data_o   <= 32'h0000_0000;
      PIP_TRAP_o       <= 1'b0;
    end else begin
      case (wb_sel_s)
        WB_PASS: begin
          PIP_use_mem_o    <= PIP_use_mem_i;
          PIP_write_reg_o  <= PIP_write_reg_i;
          PIP_rd_o         <= PIP_rd_i;
          PIP_alu_result_o <= PIP_alu_result_i;
          PIP_mem_data_o   <= 32'h0000_0000;
          PIP_TRAP_o       <= 1'b0;
        end
        WB_TRAP: begin
          PIP_use_mem_o    <= 1'b0;
          PIP_write_reg_o  <= 1'b0;
          PIP_rd_o         <= PIP_rd_i;
          PIP_alu_result_o <= PIP_alu_result_i;
          PIP_mem_data_o   <= 32'h0000_0000;
          PIP_TRAP_o       <= 1'b1;
        end
        WB_LOAD: begin
          PIP_use_mem_o    <= PIP_use_mem_i;
          PIP_write_reg_o  <= PIP_write_reg_i;
          PIP_rd_o         <= PIP_rd_i;
          PIP_alu_result_o <= PIP_alu_result_i;
          PIP_mem_data_o   <= load_data_s;
          PIP_TRAP_o       <= 1'b0;
        end
        default: begin
          PIP_use_mem_o    <= 1'b0;
          PIP_write_reg_o  <= 1'b0;
          PIP_rd_o         <= 5'd0;
          PIP_alu_result_o <= 32'h0000_0000;
          PIP_mem_data_o   <= 32'h0000_0000;
          PIP_TRAP_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        write_mem, read_mem, mem_unsigned, use_mem, write_reg, trap_in;
  logic [31:0] alu_result, second_operand;
  logic [1:0]  mem_size;
  logic [4:0]  rd;
  logic        req_valid, req_ready, we, rsp_valid, stall;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        use_mem_o, write_reg_o, trap_o;
  logic [4:0]  rd_o;
  logic [31:0] alu_o, mem_data_o;

  int checks = 0;
  int errors = 0;

  memory_stage #(.ADDR_WIDTH(32)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .PIP_write_mem_i      (write_mem),
    .PIP_read_mem_i       (read_mem),
    .PIP_alu_result_i     (alu_result),
    .PIP_second_operand_i (second_operand),
    .PIP_mem_size_i       (mem_size),
    .PIP_mem_unsigned_i   (mem_unsigned),
    .PIP_use_mem_i        (use_mem),
    .PIP_write_reg_i      (write_reg),
    .PIP_rd_i             (rd),
    .PIP_TRAP_i           (trap_in),
    .dmem_req_valid_o     (req_valid),
    .dmem_req_ready_i     (req_ready),
    .dmem_addr_o          (addr),
    .dmem_we_o            (we),
    .dmem_be_o            (be),
    .dmem_wdata_o         (wdata),
    .dmem_rsp_valid_i     (rsp_valid),
    .dmem_rdata_i         (rdata),
    .stall_o              (stall),
    .PIP_use_mem_o        (use_mem_o),
    .PIP_write_reg_o      (write_reg_o),
    .PIP_rd_o             (rd_o),
    .PIP_alu_result_o     (alu_o),
    .PIP_mem_data_o       (mem_data_o),
    .PIP_TRAP_o           (trap_o)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    write_mem = 1'b0; read_mem = 1'b0; mem_unsigned = 1'b0; use_mem = 1'b0;
    write_reg = 1'b0; trap_in = 1'b0; alu_result = 32'h0; second_operand = 32'h0;
    mem_size = 2'b00; rd = 5'd0; req_ready = 1'b0; rsp_valid = 1'b0; rdata = 32'h0;
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [31:0] a, input logic [1:0] sz, input logic uns, input logic [4:0] r);
    idle_inputs();
    read_mem = 1'b1; use_mem = 1'b1; write_reg = 1'b1;
    alu_result = a; mem_size = sz; mem_unsigned = uns; rd = r;
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    #12;
    check("reset_alu", alu_o, 32'h0);
    check("reset_wr", {31'b0, write_reg_o}, 32'h0);
    check("reset_stall", {31'b0, stall}, 32'h0);
    reset_n = 1'b1;
    step();

    // ADD: pass-through, response in IDLE ignored
    alu_result = 32'h0000_1234; rd = 5'd5; write_reg = 1'b1;
    rsp_valid = 1'b1; rdata = 32'hFFFF_FFFF;
    #3;
    check("add_stall", {31'b0, stall}, 32'h0);
    check("add_req", {31'b0, req_valid}, 32'h0);
    step();
    check("add_alu", alu_o, 32'h0000_1234);
    check("add_rd", {27'b0, rd_o}, 32'd5);
    check("add_wr", {31'b0, write_reg_o}, 32'h1);
    check("add_memdata", mem_data_o, 32'h0);

    // SB 0x1003
    idle_inputs();
    write_mem = 1'b1; mem_size = 2'b00; alu_result = 32'h0000_1003;
    second_operand = 32'h0000_00AB; req_ready = 1'b1;
    #3;
    check("sb_req", {31'b0, req_valid}, 32'h1);
    check("sb_addr", addr, 32'h0000_1000);
    check("sb_be", {28'b0, be}, 32'h8);
    check("sb_wdata", wdata, 32'hABAB_ABAB);
    check("sb_we", {31'b0, we}, 32'h1);
    check("sb_stall", {31'b0, stall}, 32'h0);
    step();
    check("sb_wb_alu", alu_o, 32'h0000_1003);

    // SH 0x1002, first not ready
    idle_inputs();
    write_mem = 1'b1; mem_size = 2'b01; alu_result = 32'h0000_1002;
    second_operand = 32'h1234_5678; req_ready = 1'b0;
    #3;
    check("sh_stall_nrdy", {31'b0, stall}, 32'h1);
    check("sh_be", {28'b0, be}, 32'hC);
    check("sh_wdata", wdata, 32'h5678_5678);
    step();
    check("sh_bubble_alu", alu_o, 32'h0);
    req_ready = 1'b1;
    #3;
    check("sh_stall_rdy", {31'b0, stall}, 32'h0);
    step();
    check("sh_wb_alu", alu_o, 32'h0000_1002);

    // LB 0x2002 signed, minimum latency
    set_load(32'h0000_2002, 2'b00, 1'b0, 5'd7);
    req_ready = 1'b1;
    #3;
    check("lb_req", {31'b0, req_valid}, 32'h1);
    check("lb_we", {31'b0, we}, 32'h0);
    check("lb_be", {28'b0, be}, 32'hF);
    check("lb_stall_issue", {31'b0, stall}, 32'h1);
    step();
    check("lb_bubble_wr", {31'b0, write_reg_o}, 32'h0);
    req_ready = 1'b0; rsp_valid = 1'b1; rdata = 32'h0080_0000;
    #3;
    check("lb_req_wait", {31'b0, req_valid}, 32'h0);
    check("lb_stall_rsp", {31'b0, stall}, 32'h0);
    step();
    check("lb_data", mem_data_o, 32'hFFFF_FF80);
    check("lb_usemem", {31'b0, use_mem_o}, 32'h1);
    check("lb_rd", {27'b0, rd_o}, 32'd7);
    check("lb_alu", alu_o, 32'h0000_2002);

    // LHU 0x2002: two not-ready cycles, response three cycles after acceptance
    set_load(32'h0000_2002, 2'b01, 1'b1, 5'd9);
    for (int i = 0; i < 2; i++) begin
      #3;
      check("lhu_stall_nrdy", {31'b0, stall}, 32'h1);
      check("lhu_req_nrdy", {31'b0, req_valid}, 32'h1);
      step();
      check("lhu_bubble_nrdy", {31'b0, use_mem_o}, 32'h0);
    end
    req_ready = 1'b1;
    #3;
    check("lhu_stall_acc", {31'b0, stall}, 32'h1);
    step();
    req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #3;
      check("lhu_stall_wait", {31'b0, stall}, 32'h1);
      check("lhu_req_wait", {31'b0, req_valid}, 32'h0);
      step();
      check("lhu_bubble_wait", {31'b0, write_reg_o}, 32'h0);
    end
    rsp_valid = 1'b1; rdata = 32'hBEEF_0000;
    #3;
    check("lhu_stall_rsp", {31'b0, stall}, 32'h0);
    step();
    check("lhu_data", mem_data_o, 32'h0000_BEEF);
    check("lhu_rd", {27'b0, rd_o}, 32'd9);

    // LW misaligned: trap, no request
    set_load(32'h0000_2001, 2'b10, 1'b0, 5'd3);
    req_ready = 1'b1;
    #3;
    check("lw_mis_req", {31'b0, req_valid}, 32'h0);
    check("lw_mis_stall", {31'b0, stall}, 32'h0);
    step();
    check("lw_mis_trap", {31'b0, trap_o}, 32'h1);
    check("lw_mis_wr", {31'b0, write_reg_o}, 32'h0);
    check("lw_mis_usemem", {31'b0, use_mem_o}, 32'h0);

    // Store with upstream trap
    idle_inputs();
    write_mem = 1'b1; mem_size = 2'b10; alu_result = 32'h0000_4000;
    trap_in = 1'b1; req_ready = 1'b1;
    #3;
    check("st_trap_req", {31'b0, req_valid}, 32'h0);
    check("st_trap_stall", {31'b0, stall}, 32'h0);
    step();
    check("st_trap_out", {31'b0, trap_o}, 32'h1);

    // Store with illegal size
    idle_inputs();
    write_mem = 1'b1; mem_size = 2'b11; alu_result = 32'h0000_4000; req_ready = 1'b1;
    #3;
    check("st_ill_req", {31'b0, req_valid}, 32'h0);
    step();
    check("st_ill_trap", {31'b0, trap_o}, 32'h1);

    // Plain op clears the trap
    idle_inputs();
    alu_result = 32'h0000_0055; rd = 5'd1; write_reg = 1'b1;
    step();
    check("clr_trap", {31'b0, trap_o}, 32'h0);

    // Reset while waiting for a load response
    set_load(32'h0000_3000, 2'b10, 1'b0, 5'd4);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_alu", alu_o, 32'h0);
    check("rst_mid_rd", {27'b0, rd_o}, 32'h0);
    idle_inputs();
    #2;
    reset_n = 1'b1;
    step();
    rsp_valid = 1'b1; rdata = 32'hCAFE_F00D;
    #3;
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_req", {31'b0, req_valid}, 32'h0);
    step();
    check("rst_memdata", mem_data_o, 32'h0);
    check("rst_usemem", {31'b0, use_mem_o}, 32'h0);
    rsp_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
